// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC-source encodings, NOP word, reset PC, IF/ID payload.
// No logic, no latency.
// No flow control.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Two-bit PCSource from the ID-stage controller; 2'b11 is reserved and acts as sequential
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: imem port, hazard/redirect inputs, IF/ID outputs, ID/EX flush.
// No latency of its own.
// stall is the only hold signal; redirects are one-cycle pulses.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  id_pcsource;
  logic [31:0] id_rs_data;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        flush_idex;

  modport master (
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, flush_idex,
    input  imem_rdata, stall, id_pcsource, id_rs_data, ex_branch_taken, ex_branch_target
  );

  modport slave (
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, flush_idex,
    output imem_rdata, stall, id_pcsource, id_rs_data, ex_branch_taken, ex_branch_target
  );
endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register holding instruction, PC+4 and valid.
// 1-cycle latency from i_d to o_q.
// i_hold freezes contents; i_bubble loads a NOP bubble and overrides i_hold.
module ifid_reg
  import pipeline_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_hold,
  input  logic  i_bubble,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  // Bubble beats hold so a redirect can squash a stalled wrong-path instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= IFID_BUBBLE;
    end else if (i_bubble) begin
      r_q <= IFID_BUBBLE;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC redirect priority, IF/ID register.
// Fetch-to-ID latency 1 cycle; a branch redirect costs 2 bubbles, a jump 1.
// stall freezes PC and IF/ID unless an EX branch is taken, which always wins.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_stage_if.master  bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_jr_target;
  logic [31:0] w_branch_target;
  logic        w_id_jump;
  logic        w_bubble;
  ifid_t       w_ifid_d;
  ifid_t       w_ifid_q;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_jump_target   = {w_ifid_q.pc_plus4[31:28], w_ifid_q.instr[25:0], 2'b00};
  assign w_jr_target     = bus.id_rs_data & 32'hFFFF_FFFC;
  assign w_branch_target = bus.ex_branch_target & 32'hFFFF_FFFC;

  // A jump only counts when the instruction decoded in ID is real, never a bubble
  assign w_id_jump = w_ifid_q.valid &&
                     ((bus.id_pcsource == PCSRC_JUMP) || (bus.id_pcsource == PCSRC_JR));

  // Next-PC priority: EX branch, then stall hold, then ID jump, then sequential
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (bus.ex_branch_taken) begin
      w_pc_next = w_branch_target;
    end else if (bus.stall) begin
      w_pc_next = r_pc;
    end else if (w_id_jump) begin
      w_pc_next = (bus.id_pcsource == PCSRC_JR) ? w_jr_target : w_jump_target;
    end
  end

  // PC register; reset restarts fetch at RESET_PC immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // A jump deferred by a stall must not squash yet, so it only bubbles when not stalled
  assign w_bubble = bus.ex_branch_taken | (~bus.stall & w_id_jump);

  assign w_ifid_d = '{instr: bus.imem_rdata, pc_plus4: w_pc_plus4, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst      (reset),
    .i_hold   (bus.stall),
    .i_bubble (w_bubble),
    .i_d      (w_ifid_d),
    .o_q      (w_ifid_q)
  );

  assign bus.imem_addr     = r_pc;
  assign bus.ifid_instr    = w_ifid_q.instr;
  assign bus.ifid_pc_plus4 = w_ifid_q.pc_plus4;
  assign bus.ifid_valid    = w_ifid_q.valid;
  assign bus.flush_idex    = bus.ex_branch_taken & ~reset;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized redirects/stalls.
// Reference model tracks architectural PC and IF/ID contents per clock edge.
// Instruction memory is a combinational address-hash with two fixed words at 0 and 4.
module tb_if_fetch_stage;

  logic clk;
  logic reset;
  logic [31:0] word0;

  int n_tests;
  int n_fail;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hash_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_rdata = (bus.imem_addr == 32'h0) ? word0 :
                          (bus.imem_addr == 32'h4) ? 32'h2009_0002 :
                          hash_word(bus.imem_addr);

  function automatic logic [31:0] mem_ref(input logic [31:0] a);
    if (a == 32'h0) return word0;
    if (a == 32'h4) return 32'h2009_0002;
    return hash_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".addr"},  bus.imem_addr, m_pc);
    chk({tag, ".instr"}, bus.ifid_instr, m_instr);
    chk({tag, ".pc4"},   bus.ifid_pc_plus4, m_pc4);
    chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, m_valid});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model and DUT, check state
  task automatic step(input string tag, input logic st, input logic [1:0] src,
                      input logic [31:0] rs, input logic br, input logic [31:0] tgt);
    logic [31:0] p4;
    logic        jmp;
    bus.stall = st; bus.id_pcsource = src; bus.id_rs_data = rs;
    bus.ex_branch_taken = br; bus.ex_branch_target = tgt;
    #1;
    chk({tag, ".flush"}, {31'd0, bus.flush_idex}, {31'd0, br});
    chk({tag, ".pre_addr"}, bus.imem_addr, m_pc);
    p4  = m_pc + 32'd4;
    jmp = m_valid && (src == 2'b01 || src == 2'b10);
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (st) begin
      // frozen
    end else if (jmp) begin
      m_pc = (src == 2'b01) ? {m_pc4[31:28], m_instr[25:0], 2'b00} : {rs[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem_ref(m_pc); m_pc4 = p4; m_valid = 1'b1; m_pc = p4;
    end
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    model_reset();
    chk_state("rst");
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    word0 = 32'h2008_0001;
    reset = 1'b1;
    bus.stall = 1'b0; bus.id_pcsource = 2'b00; bus.id_rs_data = 32'h0;
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_0abc;
    model_reset();

    // Reset state, with a branch pulse held during reset: flush must stay low
    @(posedge clk); @(posedge clk); #1;
    chk("reset.flush", {31'd0, bus.flush_idex}, 32'd0);
    chk_state("reset");
    bus.ex_branch_taken = 1'b0;
    #2 reset = 1'b0;

    // Free run from RESET_PC
    step("run0", 0, 2'b00, 0, 0, 0);
    chk("run0.instr_k", bus.ifid_instr, 32'h2008_0001);
    step("run1", 0, 2'b00, 0, 0, 0);
    chk("run1.instr_k", bus.ifid_instr, 32'h2009_0002);
    chk("run1.pc4_k", bus.ifid_pc_plus4, 32'h8);
    step("run2", 0, 2'b00, 0, 0, 0);
    step("rsvd", 0, 2'b11, 32'hdead_beef, 0, 0);

    // j in ID: 0x08000010 fetched from 0 jumps to 0x40
    word0 = 32'h0800_0010;
    do_reset();
    step("j.fetch", 0, 2'b00, 0, 0, 0);
    step("j.go", 0, 2'b01, 0, 0, 0);
    chk("j.addr_k", bus.imem_addr, 32'h40);
    chk("j.valid_k", {31'd0, bus.ifid_valid}, 32'd0);

    // jr deferred by a 2-cycle stall, then 0x103 -> 0x100
    step("jr.fill", 0, 2'b00, 0, 0, 0);
    step("jr.st0", 1, 2'b10, 32'h0000_0103, 0, 0);
    step("jr.st1", 1, 2'b10, 32'h0000_0103, 0, 0);
    step("jr.go", 0, 2'b10, 32'h0000_0103, 0, 0);
    chk("jr.addr_k", bus.imem_addr, 32'h100);

    // Branch wins over stall and jump in the same cycle
    step("bj.fill", 0, 2'b00, 0, 0, 0);
    step("bj.go", 1, 2'b01, 0, 1, 32'h0000_0200);
    chk("bj.addr_k", bus.imem_addr, 32'h200);
    // branch while IF/ID already holds a bubble
    step("bb.go", 0, 2'b00, 0, 1, 32'h0000_0302);

    // Wrap-around at the top of the address space
    step("wrap.br", 0, 2'b00, 0, 1, 32'hFFFF_FFFF);
    chk("wrap.pc_k", bus.imem_addr, 32'hFFFF_FFFC);
    step("wrap.seq", 0, 2'b00, 0, 0, 0);
    chk("wrap.addr_k", bus.imem_addr, 32'h0);
    chk("wrap.pc4_k", bus.ifid_pc_plus4, 32'h0);

    // Randomized mix of stalls, jumps and branches
    for (int i = 0; i < 400; i++) begin
      logic st, br;
      logic [1:0] src;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      src = 2'($urandom_range(0, 3));
      step("rnd", st, src, $urandom, br, $urandom);
    end

    // Async reset between edges clears everything immediately
    step("ar.pre", 0, 2'b00, 0, 0, 0);
    #2 reset = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    model_reset();
    chk_state("ar.now");
    chk("ar.flush", {31'd0, bus.flush_idex}, 32'd0);
    bus.ex_branch_taken = 1'b0;
    #2 reset = 1'b0;
    step("ar.post", 0, 2'b00, 0, 0, 0);
    chk("ar.pc4_k", bus.ifid_pc_plus4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, sitting upstream of the ID-stage controller. It owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register whose instruction word feeds the controller's OpCode/Funct decode. It also consumes the controller's PC-source decision (j/jal, jr/jalr) and the EX-stage branch outcome to redirect fetch, squash wrong-path instructions and honour hazard stalls.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_addr` out 32: fetch address, always equal to the PC register.
- `imem_rdata` in 32: instruction word, combinational read of `imem_addr`, valid in the same cycle.
- `stall` in 1: load-use hold from the hazard unit.
- `id_pcsource` in 2: controller decode of the ID instruction; 00 sequential, 01 j/jal, 10 jr/jalr, 11 reserved and treated as 00.
- `id_rs_data` in 32: forwarded rs value, used as the jr/jalr target.
- `ex_branch_taken` in 1: branch in EX resolved taken.
- `ex_branch_target` in 32: branch target from EX.
- `ifid_instr` out 32: IF/ID instruction register.
- `ifid_pc_plus4` out 32: IF/ID PC+4 register.
- `ifid_valid` out 1: IF/ID holds a real instruction, not a bubble.
- `flush_idex` out 1: tells the ID/EX register to load a bubble this edge.

## Operation
- No branch delay slots. Every redirect squashes the younger wrong-path instructions.
- `pc_plus4 = pc + 4`, taken modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Jump target: `{ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}`.
- jr/jalr target: `{id_rs_data[31:2], 2'b00}`.
- Branch target: `{ex_branch_target[31:2], 2'b00}`. Redirect targets always have their low two bits cleared.
- ID jump is effective only when `ifid_valid` = 1 and `id_pcsource` is 01 or 10.
- Per-edge priority, highest first:
  1. **EX branch taken:** PC ← branch target; IF/ID ← bubble. This overrides any stall and any ID jump, because the ID instruction is itself wrong-path.
  2. **Stall:** PC and IF/ID hold unchanged. An ID jump is deferred until the stall drops, because jr may be waiting on a load.
  3. **Effective ID jump:** PC ← jump target or jr target; IF/ID ← bubble, squashing the sequentially fetched instruction.
  4. **Otherwise:** PC ← pc_plus4; IF/ID ← {imem_rdata, pc_plus4, valid = 1}.
- Bubble encoding: instr = 32'h0000_0000 (sll $0,$0,0 NOP), pc_plus4 = 0, valid = 0.
- `flush_idex = ex_branch_taken & ~reset`, combinational.

## Timing
- Reset values:
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `ifid_instr` = 0, `ifid_pc_plus4` = 0, `ifid_valid` = 0.
  - `flush_idex` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. The first fetch after reset deassertion comes from `RESET_PC`.
- Fetch-to-ID latency is 1 cycle: the word at PC in cycle n appears on `ifid_instr` in cycle n+1.
- EX branch taken in cycle n: `imem_addr` = target in n+1; target instruction is in ID in n+2; 2 bubbles total (IF/ID and ID/EX).
- ID jump in cycle n: `imem_addr` = target in n+1; 1 bubble.
- Stall held for k cycles: PC and IF/ID frozen for k edges; normal flow resumes on the first edge with `stall` = 0.
- Stall and branch taken in the same cycle: the branch wins, and the stall is dropped for that edge.
- Branch taken while `ifid_valid` = 0: the redirect proceeds identically.

## Structure
- Shared package `pipeline_pkg`, containing:
  - `NOP_INSTR` = 32'h0.
  - PC-source encodings `PCSRC_SEQ` / `PCSRC_JUMP` / `PCSRC_JR`, matching the controller's two-bit PCSource.
  - Default `RESET_PC`.
- One sub-module, `ifid_reg`: holds the instruction, PC+4 and valid fields, with async reset, `hold`, and `bubble` inputs, where bubble takes priority over hold. It is reused by later pipeline-register work.
- Next-PC mux and priority logic live in `if_fetch_stage` itself.

## Test plan
- **Reset then free run:** reset with `RESET_PC` = 0; memory holds 0x20080001 at address 0 and 0x20090002 at 4; release reset → `imem_addr` reads 0, 4, 8; `ifid_instr` = 0x20080001 then 0x20090002, with `ifid_pc_plus4` = 4 then 8 and `ifid_valid` = 1.
- **j in ID:** instruction 0x08000010 at PC 0x0 is in ID with `id_pcsource` = 01 → next `imem_addr` = 0x40; next `ifid_valid` = 0 and `ifid_instr` = 0.
- **jr with stall:** `id_pcsource` = 10, `id_rs_data` = 0x0000_0103, `stall` = 1 for 2 cycles → PC held for 2 edges, then `imem_addr` = 0x100 with one bubble.
- **Branch over jump:** `ex_branch_taken` = 1, `ex_branch_target` = 0x200, `id_pcsource` = 01, `stall` = 1, all in the same cycle → `imem_addr` = 0x200; `flush_idex` = 1 that cycle; `ifid_valid` = 0.
- **Wrap-around:** PC = 0xFFFF_FFFC with no control events → next `imem_addr` = 0x0 and `ifid_pc_plus4` = 0x0.
- **Async reset mid-stream:** assert `reset` between clock edges → all outputs take their reset values immediately; after release, fetch restarts at `RESET_PC`.
